// File: rtl/mc_mem_port_if.sv
// Unified memory bus between the multi-cycle core's memory port and the memory system.
// The master side issues one request and holds it until the slave acknowledges.
interface mc_mem_port_if;
    logic        bus_req;
    logic        bus_we;
    logic        bus_instr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_instr, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_instr, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mc_mem_port.sv
// Memory access port of the multi-cycle RV32I core: turns controller strobes into one bus
// request/ack transaction with store lane steering, load extension, alignment checks and timeout.
module mc_mem_port #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_d_mem,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        misalign,
    output logic        access_err,
    output logic        timeout_err,
    mc_mem_port_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT_CYCLES);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_bus_req;
    logic            r_bus_we;
    logic            r_bus_instr;
    logic [31:0]     r_bus_addr;
    logic [3:0]      r_bus_be;
    logic [31:0]     r_bus_wdata;
    logic [31:0]     r_rdata;
    logic            r_rdata_valid;
    logic            r_busy;
    logic            r_misalign;
    logic            r_access_err;
    logic            r_timeout_err;
    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_unsigned;

    state_t          w_state_next;
    logic [TO_W-1:0] w_cnt_next;
    logic [TO_W-1:0] w_cnt_inc;
    logic [31:0]     w_rdata_next;
    logic            w_rdata_valid_next;
    logic            w_misalign_next;
    logic            w_access_err_next;
    logic            w_timeout_err_next;
    logic            w_latch;
    logic [1:0]      w_size_eff;
    logic            w_bad;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;

    // Fetches are always full words regardless of what the size field carries.
    assign w_size_eff = i_d_mem ? mem_size : 2'b10;

    always_comb begin
        w_bad   = 1'b0;
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (w_size_eff)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_bad   = addr[0];
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            2'b10: w_bad = (addr[1:0] != 2'b00);
            default: w_bad = 1'b1;
        endcase
    end

    assign w_byte = bus.bus_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = bus.bus_rdata[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = bus.bus_rdata;
        endcase
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_rdata_next       = r_rdata;
        w_rdata_valid_next = 1'b0;
        w_misalign_next    = 1'b0;
        w_access_err_next  = 1'b0;
        w_timeout_err_next = 1'b0;
        w_latch            = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_r | mem_w) begin
                    if (mem_r & mem_w) begin
                        w_access_err_next = 1'b1;
                    end else if (w_bad) begin
                        w_misalign_next = 1'b1;
                    end else begin
                        w_state_next = REQ;
                        w_cnt_next   = '0;
                        w_latch      = 1'b1;
                    end
                end
            end
            REQ: begin
                w_cnt_next = w_cnt_inc;
                // An ack arriving on the timeout cycle still completes the access.
                if (bus.bus_ack) begin
                    w_state_next = DONE;
                    if (!r_bus_we) begin
                        w_rdata_next       = w_load;
                        w_rdata_valid_next = 1'b1;
                    end
                end else if (w_cnt_inc == TO_VAL) begin
                    w_state_next       = IDLE;
                    w_timeout_err_next = 1'b1;
                end
            end
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_instr   <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wdata   <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_misalign    <= 1'b0;
            r_access_err  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_lane        <= '0;
            r_size        <= '0;
            r_unsigned    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_bus_req     <= (w_state_next == REQ);
            r_busy        <= (w_state_next != IDLE);
            r_rdata       <= w_rdata_next;
            r_rdata_valid <= w_rdata_valid_next;
            r_misalign    <= w_misalign_next;
            r_access_err  <= w_access_err_next;
            r_timeout_err <= w_timeout_err_next;
            if (w_latch) begin
                r_bus_we    <= mem_w;
                r_bus_instr <= ~i_d_mem;
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
                r_lane      <= addr[1:0];
                r_size      <= w_size_eff;
                r_unsigned  <= load_unsigned | ~i_d_mem;
            end
        end
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_instr = r_bus_instr;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign busy        = r_busy;
    assign misalign    = r_misalign;
    assign access_err  = r_access_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mc_mem_port.sv
// Bench for mc_mem_port: table-driven accesses with a read-data scoreboard, plus timeout,
// ack/timeout collision, reset-during-request and stray-ack sequences.
module tb_mc_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_d_mem;
    logic        mem_r;
    logic        mem_w;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        misalign;
    logic        access_err;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mc_mem_port_if bus();

    mc_mem_port #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_d_mem       (i_d_mem),
        .mem_r         (mem_r),
        .mem_w         (mem_w),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid),
        .busy          (busy),
        .misalign      (misalign),
        .access_err    (access_err),
        .timeout_err   (timeout_err),
        .bus           (bus)
    );

    typedef enum int {K_RD, K_WR, K_MIS, K_AERR} kind_t;

    typedef struct {
        string       name;
        logic        d_mem;
        logic        r;
        logic        w;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          dly;
        kind_t       kind;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic d_mem, input logic r, input logic w,
                                input logic [1:0] size, input logic uns, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] brd, input int dly,
                                input kind_t kind, input logic [3:0] be, input logic [31:0] bwd,
                                input logic [31:0] rd);
        vec_t v;
        v.name = name; v.d_mem = d_mem; v.r = r; v.w = w; v.size = size; v.uns = uns;
        v.addr = a; v.wdata = wd; v.brd = brd; v.dly = dly; v.kind = kind;
        v.be = be; v.bwd = bwd; v.rd = rd;
        return v;
    endfunction

    // Scoreboard: every rdata_valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rdata_valid) begin
            if (exp_q.size() == 0) chk("spurious_rdata_valid", 32'd1, 32'd0);
            else                   chk("rdata", rdata, exp_q.pop_front());
        end
    end

    task automatic start_access(input logic d_mem, input logic r, input logic w, input logic [1:0] size,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        i_d_mem = d_mem; mem_r = r; mem_w = w; mem_size = size;
        load_unsigned = uns; addr = a; wdata = wd;
        @(negedge clk);
        mem_r = 1'b0; mem_w = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bus.bus_rdata = v.brd;
        if (v.kind == K_RD) begin
            exp_q.push_back(v.rd);
            last_rd = v.rd;
        end
        start_access(v.d_mem, v.r, v.w, v.size, v.uns, v.addr, v.wdata);
        case (v.kind)
            K_MIS: begin
                chk({v.name, ".misalign"}, {31'd0, misalign}, 32'd1);
                chk({v.name, ".bus_req"}, {31'd0, bus.bus_req}, 32'd0);
                chk({v.name, ".busy"}, {31'd0, busy}, 32'd0);
            end
            K_AERR: begin
                chk({v.name, ".access_err"}, {31'd0, access_err}, 32'd1);
                chk({v.name, ".bus_req"}, {31'd0, bus.bus_req}, 32'd0);
                chk({v.name, ".busy"}, {31'd0, busy}, 32'd0);
            end
            default: begin
                chk({v.name, ".bus_req"}, {31'd0, bus.bus_req}, 32'd1);
                chk({v.name, ".busy"}, {31'd0, busy}, 32'd1);
                chk({v.name, ".bus_addr"}, bus.bus_addr, v.addr & 32'hFFFF_FFFC);
                chk({v.name, ".bus_be"}, {28'd0, bus.bus_be}, {28'd0, v.be});
                chk({v.name, ".bus_we"}, {31'd0, bus.bus_we}, {31'd0, v.kind == K_WR});
                chk({v.name, ".bus_instr"}, {31'd0, bus.bus_instr}, {31'd0, ~v.d_mem});
                if (v.kind == K_WR) chk({v.name, ".bus_wdata"}, bus.bus_wdata, v.bwd);
                repeat (v.dly) @(negedge clk);
                chk({v.name, ".req_held"}, {31'd0, bus.bus_req}, 32'd1);
                bus.bus_ack = 1'b1;
                @(negedge clk);
                bus.bus_ack = 1'b0;
                chk({v.name, ".req_dropped"}, {31'd0, bus.bus_req}, 32'd0);
                chk({v.name, ".rdata_valid"}, {31'd0, rdata_valid}, {31'd0, v.kind == K_RD});
                @(negedge clk);
                chk({v.name, ".busy_end"}, {31'd0, busy}, 32'd0);
                chk({v.name, ".valid_end"}, {31'd0, rdata_valid}, 32'd0);
            end
        endcase
        $display("[TB] %s: addr=%h be=%b rdata=%h", v.name, v.addr, bus.bus_be, rdata);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk("fetch",   1'b0, 1, 0, 2'b11, 0, 32'h100, 32'h0, 32'h00500093, 2, K_RD,  4'b1111, 32'h0, 32'h00500093);
        vecs[1]  = mk("lb",      1'b1, 1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF1234, 1, K_RD,  4'b1000, 32'h0, 32'hFFFFFF80);
        vecs[2]  = mk("lbu",     1'b1, 1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF1234, 0, K_RD,  4'b1000, 32'h0, 32'h00000080);
        vecs[3]  = mk("sh",      1'b1, 0, 1, 2'b01, 0, 32'h206, 32'h0000BEEF, 32'h0, 1, K_WR, 4'b1100, 32'hBEEFBEEF, 32'h0);
        vecs[4]  = mk("lh_hi",   1'b1, 1, 0, 2'b01, 0, 32'h202, 32'h0, 32'h80FF1234, 0, K_RD,  4'b1100, 32'h0, 32'hFFFF80FF);
        vecs[5]  = mk("lhu_lo",  1'b1, 1, 0, 2'b01, 1, 32'h200, 32'h0, 32'h80FF9234, 2, K_RD,  4'b0011, 32'h0, 32'h00009234);
        vecs[6]  = mk("lb_b1",   1'b1, 1, 0, 2'b00, 0, 32'h201, 32'h0, 32'h80FF1234, 0, K_RD,  4'b0010, 32'h0, 32'h00000012);
        vecs[7]  = mk("sb",      1'b1, 0, 1, 2'b00, 0, 32'h202, 32'h123456A5, 32'h0, 0, K_WR, 4'b0100, 32'hA5A5A5A5, 32'h0);
        vecs[8]  = mk("sw",      1'b1, 0, 1, 2'b10, 0, 32'h20C, 32'hDEADBEEF, 32'h0, 1, K_WR, 4'b1111, 32'hDEADBEEF, 32'h0);
        vecs[9]  = mk("lw_mis",  1'b1, 1, 0, 2'b10, 0, 32'h202, 32'h0, 32'h0, 0, K_MIS,  4'b0000, 32'h0, 32'h0);
        vecs[10] = mk("lh_mis",  1'b1, 1, 0, 2'b01, 0, 32'h201, 32'h0, 32'h0, 0, K_MIS,  4'b0000, 32'h0, 32'h0);
        vecs[11] = mk("size11",  1'b1, 1, 0, 2'b11, 0, 32'h200, 32'h0, 32'h0, 0, K_MIS,  4'b0000, 32'h0, 32'h0);
        vecs[12] = mk("rw_both", 1'b1, 1, 1, 2'b10, 0, 32'h200, 32'h0, 32'h0, 0, K_AERR, 4'b0000, 32'h0, 32'h0);
        vecs[13] = mk("fetch_mis", 1'b0, 1, 0, 2'b00, 0, 32'h102, 32'h0, 32'h0, 0, K_MIS, 4'b0000, 32'h0, 32'h0);
        vecs[14] = mk("lw",      1'b1, 1, 0, 2'b10, 0, 32'h210, 32'h0, 32'hCAFEF00D, 0, K_RD,  4'b1111, 32'h0, 32'hCAFEF00D);

        rst = 1'b1; i_d_mem = 1'b0; mem_r = 1'b0; mem_w = 1'b0; mem_size = 2'b00;
        load_unsigned = 1'b0; addr = '0; wdata = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.flags", {26'd0, rdata_valid, busy, misalign, access_err, timeout_err, bus.bus_req}, 32'h0);
        chk("rst.bus", {bus.bus_addr[27:0], bus.bus_be}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Timeout: no ack for four REQ cycles.
        start_access(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to.req_c%0d", i), {31'd0, bus.bus_req}, 32'd1);
            chk($sformatf("to.err_c%0d", i), {31'd0, timeout_err}, 32'd0);
            @(negedge clk);
        end
        chk("to.timeout_err", {31'd0, timeout_err}, 32'd1);
        chk("to.bus_req", {31'd0, bus.bus_req}, 32'd0);
        chk("to.busy", {31'd0, busy}, 32'd0);
        chk("to.rdata_hold", rdata, last_rd);
        @(negedge clk);
        chk("to.pulse_end", {31'd0, timeout_err}, 32'd0);
        $display("[TB] timeout: rdata=%h", rdata);

        // Ack on the final timeout cycle completes the read.
        bus.bus_rdata = 32'h11223344;
        exp_q.push_back(32'h11223344);
        last_rd = 32'h11223344;
        start_access(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
        repeat (3) @(negedge clk);
        bus.bus_ack = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        chk("ackto.rdata_valid", {31'd0, rdata_valid}, 32'd1);
        chk("ackto.timeout_err", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        $display("[TB] ack_vs_timeout: rdata=%h", rdata);

        // Reset mid-request, then a late ack.
        start_access(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h308, 32'h0);
        chk("rstreq.bus_req_before", {31'd0, bus.bus_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstreq.bus_req", {31'd0, bus.bus_req}, 32'd0);
        chk("rstreq.busy", {31'd0, busy}, 32'd0);
        chk("rstreq.rdata", rdata, 32'h0);
        rst = 1'b0;
        bus.bus_rdata = 32'h00000055;
        bus.bus_ack = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        chk("rstreq.late_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rstreq.late_busy", {31'd0, busy}, 32'd0);
        chk("rstreq.late_req", {31'd0, bus.bus_req}, 32'd0);
        $display("[TB] reset_in_req: busy=%b", busy);

        // Stray ack while idle.
        bus.bus_ack = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        chk("idleack.valid", {31'd0, rdata_valid}, 32'd0);
        chk("idleack.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        $display("[TB] idle_ack: busy=%b", busy);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
